// File: rtl/craft_enc_iter_if.sv
// Block interface of craft_enc_iter: host load/result signals plus the
// round-constant link to craft_round_constants.
interface craft_enc_iter_if;
  logic         start;
  logic [63:0]  pt;
  logic [127:0] key;
  logic [63:0]  tweak;
  logic [7:0]   rc;
  logic         rc_rst;
  logic         busy;
  logic         done;
  logic [63:0]  ct;

  modport master (
    output start, pt, key, tweak, rc,
    input  rc_rst, busy, done, ct
  );

  modport slave (
    input  start, pt, key, tweak, rc,
    output rc_rst, busy, done, ct
  );
endinterface

// File: rtl/craft_enc_iter.sv
// Iterative CRAFT-64/128 encryption, one round per clock, 32 rounds per block.
// Optional build macro CRAFT_ZEROIZE_EN clears key/tweak/state at completion.
module craft_enc_iter (
  input  logic            clk,
  input  logic            rst_n,
  craft_enc_iter_if.slave bus
);

  // Nibble tables, entry 0 in the top nibble
  localparam logic [63:0] PN_TAB = 64'hfcde_a98b_6547_1230;
  localparam logic [63:0] QT_TAB = 64'hcaf5_e892_b374_601d;
  localparam logic [63:0] SBOX   = 64'hcad3_ebf7_8915_0246;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t       state_q, state_d;
  logic [4:0]   rnd_q;
  logic [63:0]  s_q, t_q, qt_q, ct_q;
  logic [63:0]  k0_q, k1_q;
  logic [63:0]  tk;
  logic [63:0]  round_out;
  logic         load, advance, last;

  // Moves nibble j to position tab[j]
  function automatic logic [63:0] nib_perm(input logic [63:0] x, input logic [63:0] tab);
    logic [63:0] r;
    logic [3:0]  dst;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      dst = tab[63-4*j -: 4];
      r[63-4*int'(dst) -: 4] = x[63-4*j -: 4];
    end
    return r;
  endfunction

  function automatic logic [63:0] sub_cells(input logic [63:0] x);
    logic [63:0] r;
    logic [3:0]  n;
    r = '0;
    for (int j = 0; j < 16; j++) begin
      n = x[63-4*j -: 4];
      r[63-4*j -: 4] = SBOX[63-4*int'(n) -: 4];
    end
    return r;
  endfunction

  // The final round skips PermuteNibbles and the S-box layer
  function automatic logic [63:0] craft_round(input logic [63:0] x, input logic [7:0] c,
                                              input logic [63:0] k, input logic full);
    logic [63:0] r;
    r          = x;
    r[63:48]   = x[63:48] ^ x[31:16] ^ x[15:0];
    r[47:32]   = x[47:32] ^ x[15:0];
    r[47:40]   = r[47:40] ^ c;
    r          = r ^ k;
    if (full)
      r = sub_cells(nib_perm(r, PN_TAB));
    return r;
  endfunction

  always_comb begin
    case (rnd_q[1:0])
      2'd0:    tk = k0_q ^ t_q;
      2'd1:    tk = k1_q ^ t_q;
      2'd2:    tk = k0_q ^ qt_q;
      default: tk = k1_q ^ qt_q;
    endcase
    round_out = craft_round(s_q, bus.rc, tk, rnd_q != 5'd31);
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    last    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        advance = 1'b1;
        if (rnd_q == 5'd31) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = ROUND;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd_q <= '0;
      s_q   <= '0;
      k0_q  <= '0;
      k1_q  <= '0;
      t_q   <= '0;
      qt_q  <= '0;
      ct_q  <= '0;
    end else if (load) begin
      rnd_q <= '0;
      s_q   <= bus.pt;
      k0_q  <= bus.key[127:64];
      k1_q  <= bus.key[63:0];
      t_q   <= bus.tweak;
      qt_q  <= nib_perm(bus.tweak, QT_TAB);
    end else if (advance) begin
      rnd_q <= rnd_q + 5'd1;
      if (last) begin
        ct_q <= round_out;
`ifdef CRAFT_ZEROIZE_EN
        s_q  <= '0;
        k0_q <= '0;
        k1_q <= '0;
        t_q  <= '0;
        qt_q <= '0;
`endif
      end else begin
        s_q <= round_out;
      end
    end
  end

  // Generator is parked outside ROUND so it presents 0x11 for round 0
  assign bus.rc_rst = (state_q != ROUND);
  assign bus.busy   = (state_q == ROUND);
  assign bus.done   = (state_q == DONE);
  assign bus.ct     = ct_q;

endmodule

// File: tb/tb_craft_enc_iter.sv
// Bench for craft_enc_iter: behavioural round-constant source, nibble-array
// CRAFT reference model, vector table plus directed and random sequences.
module tb_craft_enc_iter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  craft_enc_iter_if bus ();
  craft_enc_iter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;

  // CRAFT round constant sequences (a: period 15, b: period 7)
  logic [3:0] RC3 [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hc, 4'h6, 4'hb,
                           4'h5, 4'ha, 4'hd, 4'he, 4'hf, 4'h7, 4'h3};
  logic [2:0] RC4 [7]  = '{3'h1, 3'h4, 3'h2, 3'h5, 3'h6, 3'h7, 3'h3};
  int PT [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
  int QT [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
  int SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};

  // Constants generator stand-in: synchronous clear, one step per cycle
  int gcnt = 0;
  always @(posedge clk) gcnt <= bus.rc_rst ? 0 : gcnt + 1;
  always_comb bus.rc = {RC3[gcnt % 15], 1'b0, RC4[gcnt % 7]};

  function automatic logic [63:0] craft_ref(input logic [63:0] p, input logic [127:0] k,
                                            input logic [63:0] tw);
    int s[16], t[16], q[16], k0[16], k1[16], tk[4][16], tmp[16];
    logic [63:0] r;
    for (int j = 0; j < 16; j++) begin
      s[j]  = int'(p[63-4*j -: 4]);
      t[j]  = int'(tw[63-4*j -: 4]);
      k0[j] = int'(k[127-4*j -: 4]);
      k1[j] = int'(k[63-4*j -: 4]);
    end
    for (int j = 0; j < 16; j++) q[QT[j]] = t[j];
    for (int j = 0; j < 16; j++) begin
      tk[0][j] = k0[j] ^ t[j];
      tk[1][j] = k1[j] ^ t[j];
      tk[2][j] = k0[j] ^ q[j];
      tk[3][j] = k1[j] ^ q[j];
    end
    for (int rr = 0; rr < 32; rr++) begin
      for (int c = 0; c < 4; c++) begin
        s[c]   = s[c] ^ s[8+c] ^ s[12+c];
        s[4+c] = s[4+c] ^ s[12+c];
      end
      s[4] = s[4] ^ int'(RC3[rr % 15]);
      s[5] = s[5] ^ int'(RC4[rr % 7]);
      for (int j = 0; j < 16; j++) s[j] = s[j] ^ tk[rr % 4][j];
      if (rr < 31) begin
        for (int j = 0; j < 16; j++) tmp[PT[j]] = s[j];
        for (int j = 0; j < 16; j++) s[j] = SB[tmp[j]];
      end
    end
    for (int j = 0; j < 16; j++) r[63-4*j -: 4] = s[j][3:0];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge just after the accept edge
  task automatic launch(input logic [63:0] p, input logic [127:0] k, input logic [63:0] tw);
    @(negedge clk);
    bus.start = 1'b1; bus.pt = p; bus.key = k; bus.tweak = tw;
    @(negedge clk);
    bus.start = 1'b0; bus.pt = ~p; bus.key = ~k; bus.tweak = ~tw;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (bus.done !== 1'b1 && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic check_block(input string name, input logic [63:0] exp);
    int cyc;
    wait_done(cyc);
    chk({name, "_latency"}, cyc, 32);
    chk({name, "_ct"}, bus.ct, exp);
    chk({name, "_busy_at_done"}, bus.busy, 1'b0);
`ifdef CRAFT_ZEROIZE_EN
    chk({name, "_zero_s"}, dut.s_q, 64'h0);
    chk({name, "_zero_k0"}, dut.k0_q, 64'h0);
    chk({name, "_zero_k1"}, dut.k1_q, 64'h0);
    chk({name, "_zero_t"}, dut.t_q, 64'h0);
`endif
  endtask

  typedef struct {
    logic [63:0]  pt;
    logic [127:0] key;
    logic [63:0]  tweak;
    logic [63:0]  exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int cyc, gap, hold_ok, nodone_ok;
    logic [63:0]  cap, p, tw, e1, e2;
    logic [127:0] k;

    vecs[0] = '{64'h5734f006d8d88a3e, 128'h27a6781a43f364bc916708d5fbb5aeef,
                64'h5474fd49443ec95f, 64'h0};
    vecs[1] = '{64'h0, 128'h0, 64'h0, 64'h0};
    vecs[2] = '{64'hffffffffffffffff, {2{64'hffffffffffffffff}}, 64'hffffffffffffffff, 64'h0};
    vecs[3] = '{64'h0123456789abcdef, 128'hfedcba98765432100011223344556677,
                64'h0f1e2d3c4b5a6978, 64'h0};
    vecs[4] = '{64'h8000000000000001, 128'h1, 64'h8000000000000000, 64'h0};
    for (int i = 0; i < 5; i++) vecs[i].exp = craft_ref(vecs[i].pt, vecs[i].key, vecs[i].tweak);

    rst_n = 1'b0;
    bus.start = 1'b0; bus.pt = '0; bus.key = '0; bus.tweak = '0;
    repeat (3) @(negedge clk);
    chk("reset_ct", bus.ct, 64'h0);
    chk("reset_done", bus.done, 1'b0);
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_rc_rst", bus.rc_rst, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i].pt, vecs[i].key, vecs[i].tweak);
      if (i == 0) begin
        chk("first_round_rc", bus.rc, 8'h11);
        chk("first_round_rc_rst", bus.rc_rst, 1'b0);
        chk("first_round_busy", bus.busy, 1'b1);
      end
      check_block($sformatf("vec%0d", i), vecs[i].exp);
      cap = bus.ct;
      @(negedge clk);
      chk($sformatf("vec%0d_done_falls", i), bus.done, 1'b0);
      hold_ok = 1;
      repeat (10) begin
        @(negedge clk);
        if (bus.ct !== cap || bus.done !== 1'b0 || bus.busy !== 1'b0) hold_ok = 0;
      end
      chk($sformatf("vec%0d_ct_hold", i), hold_ok, 1);
    end

    // Back-to-back: second start in the DONE cycle, stray start during ROUND
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; tw = {$urandom, $urandom};
    e1 = craft_ref(p, k, tw);
    launch(p, k, tw);
    check_block("b2b_first", e1);
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; tw = {$urandom, $urandom};
    e2 = craft_ref(p, k, tw);
    bus.start = 1'b1; bus.pt = p; bus.key = k; bus.tweak = tw;
    @(negedge clk);
    bus.start = 1'b0; bus.pt = '0; bus.key = '0; bus.tweak = '0;
    repeat (10) @(negedge clk);
    bus.start = 1'b1; bus.pt = {$urandom, $urandom}; bus.tweak = {$urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(cyc);
    gap = 1 + 11 + cyc;
    chk("b2b_gap", gap, 33);
    chk("b2b_second_ct", bus.ct, e2);

    // Reset while rnd = 17
    p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; tw = {$urandom, $urandom};
    launch(p, k, tw);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset_ct", bus.ct, 64'h0);
    chk("midreset_busy", bus.busy, 1'b0);
    chk("midreset_rc_rst", bus.rc_rst, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nodone_ok = 1;
    repeat (40) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.ct !== 64'h0) nodone_ok = 0;
    end
    chk("midreset_no_done", nodone_ok, 1);
    launch(p, k, tw);
    check_block("after_reset", craft_ref(p, k, tw));

    // Random blocks against the reference model
    for (int i = 0; i < 6; i++) begin
      p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; tw = {$urandom, $urandom};
      launch(p, k, tw);
      check_block($sformatf("rand%0d", i), craft_ref(p, k, tw));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
